// File: rtl/axi_txn_arbiter.sv
// axi_txn_arbiter: round-robin tenure arbiter for one AXI request channel
// (AR or AW). A master owns the channel until its accepts stop (or the
// per-tenure cap is hit) and every response it is owed has come back.
// Optional response watchdog: define AXI_ARB_TIMEOUT_EN.
module axi_txn_arbiter #(
  parameter int NB_REQ          = 3,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024,
  localparam int OW             = $clog2(NB_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NB_REQ-1:0] req_i,
  output logic [NB_REQ-1:0] gnt_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  input  logic              m_rsp_done_i,
  output logic [OW-1:0]     owner_o,
  output logic              owner_valid_o,
  output logic [3:0]        outstanding_o,
  output logic              err_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT} state_t;

  localparam logic [3:0] MAX_OS = 4'(MAX_OUTSTANDING);

  state_t          r_state, w_next;
  logic [OW-1:0]   r_owner, r_last_ptr;
  logic [3:0]      r_out, r_iss;
  logic            r_err, r_timeout;

  logic [OW-1:0]   w_pick, w_cand;
  logic            w_found, w_any, w_own_req;
  logic            w_valid, w_acc, w_err, w_to, w_start, w_end;
  logic [3:0]      w_out_nxt, w_iss_nxt;

  assign w_any     = |req_i;
  assign w_own_req = req_i[r_owner];
  assign w_start   = (r_state == S_IDLE) && w_any;
  assign w_end     = (r_state != S_IDLE) && (w_next == S_IDLE);

  // Round-robin pick: first requester after the last owner, wrapping.
  always_comb begin
    w_pick  = r_last_ptr;
    w_cand  = r_last_ptr;
    w_found = 1'b0;
    for (int i = 1; i <= NB_REQ; i++) begin
      w_cand = OW'((int'(r_last_ptr) + i) % NB_REQ);
      if (!w_found && req_i[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // Accept / response bookkeeping; a same-cycle accept cancels a response.
  always_comb begin
    w_valid   = (r_state == S_ADDR) && w_own_req && (r_iss != MAX_OS) && !w_to;
    w_acc     = w_valid && m_ready_i;
    w_err     = m_rsp_done_i && !w_acc && (r_out == 4'd0);
    w_iss_nxt = r_iss + {3'b000, w_acc};
    w_out_nxt = r_out;
    if (w_acc && !m_rsp_done_i)
      w_out_nxt = r_out + 4'd1;
    else if (!w_acc && m_rsp_done_i && (r_out != 4'd0))
      w_out_nxt = r_out - 4'd1;
  end

`ifdef AXI_ARB_TIMEOUT_EN
  localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_wdog;

  // Watchdog: counts response-less cycles while something is owed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_wdog <= '0;
    else if (w_to || m_rsp_done_i || (r_state == S_IDLE))
      r_wdog <= '0;
    else if (r_out != 4'd0)
      r_wdog <= r_wdog + 16'd1;
  end

  assign w_to = (r_out != 4'd0) && !m_rsp_done_i && (r_wdog == WDOG_LIMIT);
`else
  assign w_to = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: stay in ADDR while the owner keeps requesting and is under cap.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_any) w_next = S_ADDR;
      S_ADDR: begin
        if (w_iss_nxt == MAX_OS)  w_next = S_WAIT;
        else if (!w_own_req)      w_next = (r_out == 4'd0) ? S_IDLE : S_WAIT;
      end
      S_WAIT: if (r_out == 4'd0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_to) w_next = S_IDLE;
  end

  // Outputs: only the owner can see a grant, and only in ADDR.
  always_comb begin
    gnt_o = '0;
    if (w_acc) gnt_o[r_owner] = 1'b1;
    m_valid_o = w_valid;
  end

  // Tenure datapath: owner, round-robin pointer, counters, pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner    <= '0;
      r_last_ptr <= OW'(NB_REQ - 1);
      r_out      <= '0;
      r_iss      <= '0;
      r_err      <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_err     <= w_err;
      r_timeout <= w_to;
      if (w_start) r_owner <= w_pick;
      if (w_end)   r_last_ptr <= r_owner;
      if (w_to) begin
        r_out <= '0;
        r_iss <= '0;
      end else begin
        r_out <= w_out_nxt;
        r_iss <= w_start ? 4'd0 : w_iss_nxt;
      end
    end
  end

  assign owner_o       = r_owner;
  assign owner_valid_o = (r_state != S_IDLE);
  assign outstanding_o = r_out;
  assign err_o         = r_err;
  assign timeout_o     = r_timeout;

endmodule

// File: tb/tb_axi_txn_arbiter.sv
// Bench for axi_txn_arbiter: behavioural tenure model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_axi_txn_arbiter;
  localparam int N   = 3;
  localparam int MAX = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req_i = '0;
  logic [N-1:0] gnt_o;
  logic         m_valid_o;
  logic         m_ready_i = 1'b0;
  logic         m_rsp_done_i = 1'b0;
  logic [1:0]   owner_o;
  logic         owner_valid_o;
  logic [3:0]   outstanding_o;
  logic         err_o, timeout_o;

  axi_txn_arbiter #(.NB_REQ(N), .MAX_OUTSTANDING(MAX), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .gnt_o(gnt_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_rsp_done_i(m_rsp_done_i),
    .owner_o(owner_o), .owner_valid_o(owner_valid_o), .outstanding_o(outstanding_o),
    .err_o(err_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: phase 0=no tenure, 1=issuing, 2=draining.
  int m_ph, m_own, m_last, m_out, m_iss, m_err;
  // Last sampled DUT values for directed literal checks.
  int a_gnt, a_vld, a_own, a_ovld, a_out, a_err;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_own = 0; m_last = N - 1; m_out = 0; m_iss = 0; m_err = 0;
  endtask

  // One clock: drive, compare against model at negedge, advance model.
  task automatic cyc(input logic [N-1:0] rq, input logic rd, input logic rs);
    int ev, eg, acc, e, nout, niss, c;
    req_i = rq; m_ready_i = rd; m_rsp_done_i = rs;
    @(negedge clk);
    ev = (m_ph == 1 && rq[m_own] && m_iss < MAX) ? 1 : 0;
    eg = (ev != 0 && rd) ? (1 << m_own) : 0;
    a_gnt = int'(gnt_o); a_vld = int'(m_valid_o); a_own = int'(owner_o);
    a_ovld = int'(owner_valid_o); a_out = int'(outstanding_o); a_err = int'(err_o);
    chk("gnt_o", a_gnt, eg);
    chk("m_valid_o", a_vld, ev);
    chk("owner_o", a_own, m_own);
    chk("owner_valid_o", a_ovld, (m_ph != 0) ? 1 : 0);
    chk("outstanding_o", a_out, m_out);
    chk("err_o", a_err, m_err);
    chk("timeout_o", int'(timeout_o), 0);
    acc  = (eg != 0) ? 1 : 0;
    e    = (rs && m_out + acc == 0) ? 1 : 0;
    nout = m_out + acc - ((rs && e == 0) ? 1 : 0);
    niss = m_iss + acc;
    case (m_ph)
      0: if (rq != 0) begin
        for (int k = N; k >= 1; k--) begin
          c = (m_last + k) % N;
          if (rq[c]) m_own = c;
        end
        m_ph = 1; niss = 0;
      end
      1: if (niss == MAX) m_ph = 2;
         else if (!rq[m_own]) begin
           if (m_out == 0) begin m_ph = 0; m_last = m_own; end
           else m_ph = 2;
         end
      default: if (m_out == 0) begin m_ph = 0; m_last = m_own; end
    endcase
    m_out = nout; m_iss = niss; m_err = e;
    @(posedge clk); #1;
  endtask

  // Let any tenure finish, answering what is owed.
  task automatic drain();
    int n;
    n = 0;
    while ((m_ph != 0 || m_err != 0) && n < 100) begin
      cyc('0, 1'b1, m_out > 0);
      n++;
    end
    chk("drain_bound", n < 100 ? 1 : 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int exp_own[4];
    int k, d1, d2, rs;
    logic [N-1:0] rq;
    exp_own = '{0, 1, 2, 0};
    model_reset();
    #1;
    chk("rst_gnt", int'(gnt_o), 0);
    chk("rst_ovld", int'(owner_valid_o), 0);
    chk("rst_out", int'(outstanding_o), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // All request, responses two cycles after each accept.
    k = 0; d1 = 0; d2 = 0;
    for (int c = 0; c < 40; c++) begin
      rs = d2;
      cyc(3'b111, 1'b1, rs[0]);
      d2 = d1; d1 = (a_gnt != 0) ? 1 : 0;
      if (a_gnt != 0) begin
        if (k < 16) chk("rr_order", a_gnt, 1 << exp_own[k / 4]);
        k++;
      end
    end
    chk("rr_pulses", k >= 16 ? 1 : 0, 1);
    drain();

    // Master 1 issues two, drops; master 2 waits its turn.
    cyc(3'b010, 1'b1, 1'b0);
    cyc(3'b010, 1'b1, 1'b0); chk("m1_acc1", a_gnt, 3'b010);
    cyc(3'b010, 1'b1, 1'b0); chk("m1_acc2", a_gnt, 3'b010);
    cyc(3'b100, 1'b1, 1'b0); chk("m1_drop_out", a_out, 2); chk("m1_drop_vld", a_vld, 0);
    cyc(3'b100, 1'b1, 1'b0); chk("m1_wait_gnt", a_gnt, 0);
    cyc(3'b100, 1'b1, 1'b1); chk("m1_wait_out2", a_out, 2);
    cyc(3'b100, 1'b1, 1'b1); chk("m1_wait_out1", a_out, 1);
    cyc(3'b100, 1'b1, 1'b0); chk("m1_wait_out0", a_out, 0); chk("m1_still_owner", a_ovld, 1);
    cyc(3'b100, 1'b1, 1'b0); chk("m1_idle", a_ovld, 0);
    cyc(3'b100, 1'b1, 1'b0); chk("next_owner", a_own, 2); chk("next_gnt", a_gnt, 3'b100);
    drain();

    // Accept and response together with two outstanding.
    cyc(3'b001, 1'b1, 1'b0);
    cyc(3'b001, 1'b1, 1'b0);
    cyc(3'b001, 1'b1, 1'b0);
    cyc(3'b001, 1'b1, 1'b1); chk("same_gnt", a_gnt, 3'b001); chk("same_out_before", a_out, 2);
    cyc(3'b001, 1'b1, 1'b0); chk("same_out_after", a_out, 2); chk("fourth_acc", a_gnt, 3'b001);
    cyc(3'b001, 1'b1, 1'b0); chk("cap_vld", a_vld, 0); chk("cap_ovld", a_ovld, 1);
    drain();

    // Spurious response while idle.
    cyc('0, 1'b1, 1'b1); chk("err_pre", a_err, 0);
    cyc('0, 1'b1, 1'b0); chk("err_pulse", a_err, 1); chk("err_out", a_out, 0);
    cyc('0, 1'b1, 1'b0); chk("err_clear", a_err, 0); chk("err_idle", a_ovld, 0);

    // Random traffic; requests held until granted.
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      cyc(rq, ($urandom % 10) < 7, (m_out > 0) ? (($urandom % 10) < 4) : (($urandom % 25) == 0));
      for (int i = 0; i < N; i++) begin
        if (a_gnt[i] && ($urandom % 2) == 0) rq[i] = 1'b0;
        if (!rq[i] && ($urandom % 10) < 3) rq[i] = 1'b1;
      end
    end
    drain();

    // Reset mid-drain with three outstanding.
    cyc(3'b001, 1'b1, 1'b0);
    cyc(3'b001, 1'b1, 1'b0);
    cyc(3'b001, 1'b1, 1'b0);
    cyc(3'b001, 1'b1, 1'b0);
    cyc(3'b000, 1'b1, 1'b0);
    chk("pre_rst_out", int'(outstanding_o), 3);
    chk("pre_rst_ovld", int'(owner_valid_o), 1);
    req_i = 3'b111;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", int'(outstanding_o), 0);
    chk("mid_rst_ovld", int'(owner_valid_o), 0);
    chk("mid_rst_own", int'(owner_o), 0);
    chk("mid_rst_gnt", int'(gnt_o), 0);
    chk("mid_rst_vld", int'(m_valid_o), 0);
    chk("mid_rst_err", int'(err_o) + int'(timeout_o), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    cyc(3'b111, 1'b1, 1'b0);
    cyc(3'b111, 1'b1, 1'b0); chk("post_rst_first", a_gnt, 3'b001);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
